// File: rtl/reveal_flood_pkg.sv
// +--------------------------------------------------------------------------+
// | reveal_flood_pkg : shared FSM encoding, neighbour offsets, width helpers |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

package reveal_flood_pkg;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_FIRST = 3'd1,
    ST_POP   = 3'd2,
    ST_SCAN  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam int NB_COUNT = 8;

  // Neighbour order: row above left-to-right, same row, row below
  localparam logic signed [1:0] NB_DX [NB_COUNT] = '{
    -2'sd1, 2'sd0, 2'sd1, -2'sd1, 2'sd1, -2'sd1, 2'sd0, 2'sd1
  };
  localparam logic signed [1:0] NB_DY [NB_COUNT] = '{
    -2'sd1, -2'sd1, -2'sd1, 2'sd0, 2'sd0, 2'sd1, 2'sd1, 2'sd1
  };

  function automatic int coord_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int count_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/reveal_flood_stack.sv
// +--------------------------------------------------------------------------+
// | reveal_stack : LIFO of packed cell coordinates; full/empty guarded       |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module reveal_stack #(
  parameter int depth = 64,
  parameter int width = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [width-1:0] push_data,
  output logic             empty,
  output logic             full,
  output logic [width-1:0] top
);

  localparam int PW = $clog2(depth + 1);
  localparam int AW = (depth > 1) ? $clog2(depth) : 1;
  localparam logic [PW-1:0] C_DEPTH = PW'(depth);

  logic [width-1:0] mem_q [depth];
  logic [PW-1:0]    ptr_q;
  logic [PW-1:0]    ptr_d;
  logic [PW-1:0]    top_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (ptr_q == '0);
  assign full    = (ptr_q == C_DEPTH);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign top_ptr = ptr_q - PW'(1);
  assign top     = mem_q[top_ptr[AW-1:0]];

  always_comb begin
    ptr_d = ptr_q;
    if (do_push) begin
      ptr_d = ptr_q + PW'(1);
    end else if (do_pop) begin
      ptr_d = ptr_q - PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // Storage carries no reset; only the pointer defines validity
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[ptr_q[AW-1:0]] <= push_data;
    end
  end

endmodule

`default_nettype wire

// File: rtl/reveal_flood.sv
// +--------------------------------------------------------------------------+
// | reveal_flood : minesweeper click handler with zero-cell flood fill       |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module reveal_flood
  import reveal_flood_pkg::*;
#(
  parameter int boardWidth  = 8,
  parameter int boardHeight = 8,
  localparam int XW = coord_w(boardWidth),
  localparam int YW = coord_w(boardHeight),
  localparam int CW = count_w(boardWidth * boardHeight)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          ack,
  input  logic [XW-1:0] startX,
  input  logic [YW-1:0] startY,
  output logic [XW-1:0] readX,
  output logic [YW-1:0] readY,
  input  logic          mineReadValue,
  input  logic [3:0]    adjReadValue,
  input  logic          revealedReadValue,
  output logic          revealWriteEn,
  output logic [XW-1:0] writeX,
  output logic [YW-1:0] writeY,
  output logic          qInit,
  output logic          qFirst,
  output logic          qPop,
  output logic          qScan,
  output logic          qDone,
  output logic          hitMine,
  output logic [CW-1:0] revealedCount
);

  localparam int SW = XW + YW;
  localparam logic [XW:0] C_W_LIM = (XW + 1)'(boardWidth);
  localparam logic [YW:0] C_H_LIM = (YW + 1)'(boardHeight);

  state_t        state_q, state_d;
  logic [XW-1:0] cur_x_q, cur_x_d;
  logic [YW-1:0] cur_y_q, cur_y_d;
  logic [2:0]    dir_q, dir_d;
  logic [CW-1:0] count_q, count_d;
  logic          hit_q, hit_d;

  logic          stk_push, stk_pop, stk_empty, stk_full;
  logic [SW-1:0] stk_push_data, stk_top;

  logic signed [1:0] dx, dy;
  logic [XW:0]   nx_ext;
  logic [YW:0]   ny_ext;
  logic          nb_in_bounds;

  // One extra bit so stepping left of 0 lands above the limit instead of wrapping
  assign dx           = NB_DX[dir_q];
  assign dy           = NB_DY[dir_q];
  assign nx_ext       = {1'b0, cur_x_q} + {{(XW - 1){dx[1]}}, dx};
  assign ny_ext       = {1'b0, cur_y_q} + {{(YW - 1){dy[1]}}, dy};
  assign nb_in_bounds = (nx_ext < C_W_LIM) && (ny_ext < C_H_LIM);

  always_comb begin
    state_d       = state_q;
    cur_x_d       = cur_x_q;
    cur_y_d       = cur_y_q;
    dir_d         = dir_q;
    count_d       = count_q;
    hit_d         = hit_q;
    readX         = cur_x_q;
    readY         = cur_y_q;
    revealWriteEn = 1'b0;
    stk_push      = 1'b0;
    stk_pop       = 1'b0;
    stk_push_data = {cur_y_q, cur_x_q};

    case (state_q)
      ST_INIT: begin
        if (start) begin
          cur_x_d = startX;
          cur_y_d = startY;
          dir_d   = 3'd0;
          count_d = '0;
          hit_d   = 1'b0;
          state_d = ST_FIRST;
        end
      end

      ST_FIRST: begin
        if (revealedReadValue) begin
          state_d = ST_DONE;
        end else begin
          revealWriteEn = 1'b1;
          count_d       = CW'(1);
          if (mineReadValue) begin
            hit_d   = 1'b1;
            state_d = ST_DONE;
          end else if (adjReadValue != 4'd0) begin
            state_d = ST_DONE;
          end else begin
            stk_push = !stk_full;
            state_d  = ST_POP;
          end
        end
      end

      ST_POP: begin
        if (stk_empty) begin
          state_d = ST_DONE;
        end else begin
          stk_pop = 1'b1;
          cur_x_d = stk_top[XW-1:0];
          cur_y_d = stk_top[SW-1:XW];
          dir_d   = 3'd0;
          state_d = ST_SCAN;
        end
      end

      ST_SCAN: begin
        readX = nx_ext[XW-1:0];
        readY = ny_ext[YW-1:0];
        if (nb_in_bounds && !revealedReadValue && !mineReadValue) begin
          revealWriteEn = 1'b1;
          count_d       = count_q + CW'(1);
          if (adjReadValue == 4'd0) begin
            stk_push      = !stk_full;
            stk_push_data = {ny_ext[YW-1:0], nx_ext[XW-1:0]};
          end
        end
        dir_d = dir_q + 3'd1;
        if (dir_q == 3'd7) begin
          state_d = ST_POP;
        end
      end

      ST_DONE: begin
        if (ack) begin
          state_d = ST_INIT;
        end
      end

      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_INIT;
      cur_x_q <= '0;
      cur_y_q <= '0;
      dir_q   <= 3'd0;
      count_q <= '0;
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_x_q <= cur_x_d;
      cur_y_q <= cur_y_d;
      dir_q   <= dir_d;
      count_q <= count_d;
      hit_q   <= hit_d;
    end
  end

  reveal_stack #(
    .depth (boardWidth * boardHeight),
    .width (SW)
  ) u_stack (
    .clk       (clk),
    .reset     (reset),
    .push      (stk_push),
    .pop       (stk_pop),
    .push_data (stk_push_data),
    .empty     (stk_empty),
    .full      (stk_full),
    .top       (stk_top)
  );

  assign writeX        = readX;
  assign writeY        = readY;
  assign qInit         = (state_q == ST_INIT);
  assign qFirst        = (state_q == ST_FIRST);
  assign qPop          = (state_q == ST_POP);
  assign qScan         = (state_q == ST_SCAN);
  assign qDone         = (state_q == ST_DONE);
  assign hitMine       = hit_q;
  assign revealedCount = count_q;

endmodule

`default_nettype wire

// File: tb/tb_reveal_flood.sv
// +--------------------------------------------------------------------------+
// | tb_reveal_flood : directed bench with behavioural 8x8 board memories     |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_reveal_flood;

  logic       clk;
  logic       reset;
  logic       start;
  logic       ack;
  logic [2:0] startX, startY;
  logic [2:0] readX, readY;
  logic       mineReadValue;
  logic [3:0] adjReadValue;
  logic       revealedReadValue;
  logic       revealWriteEn;
  logic [2:0] writeX, writeY;
  logic       qInit, qFirst, qPop, qScan, qDone;
  logic       hitMine;
  logic [6:0] revealedCount;

  logic       mine_b   [64];
  logic [3:0] adj_b    [64];
  logic       preset_b [64];
  logic       wr_b     [64];
  logic       clear_wr;
  int         wr_count;
  int         dup_writes;
  int         mine_writes;

  int checks   = 0;
  int failures = 0;

  reveal_flood #(
    .boardWidth  (8),
    .boardHeight (8)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .ack               (ack),
    .startX            (startX),
    .startY            (startY),
    .readX             (readX),
    .readY             (readY),
    .mineReadValue     (mineReadValue),
    .adjReadValue      (adjReadValue),
    .revealedReadValue (revealedReadValue),
    .revealWriteEn     (revealWriteEn),
    .writeX            (writeX),
    .writeY            (writeY),
    .qInit             (qInit),
    .qFirst            (qFirst),
    .qPop              (qPop),
    .qScan             (qScan),
    .qDone             (qDone),
    .hitMine           (hitMine),
    .revealedCount     (revealedCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    mineReadValue     = mine_b[{readY, readX}];
    adjReadValue      = adj_b[{readY, readX}];
    revealedReadValue = preset_b[{readY, readX}] | wr_b[{readY, readX}];
  end

  always @(posedge clk) begin
    if (clear_wr) begin
      for (int i = 0; i < 64; i++) wr_b[i] <= 1'b0;
      wr_count    <= 0;
      dup_writes  <= 0;
      mine_writes <= 0;
    end else if (revealWriteEn) begin
      wr_b[{writeY, writeX}] <= 1'b1;
      wr_count <= wr_count + 1;
      if (preset_b[{writeY, writeX}] || wr_b[{writeY, writeX}]) dup_writes <= dup_writes + 1;
      if (mine_b[{writeY, writeX}]) mine_writes <= mine_writes + 1;
    end
  end

  task automatic check(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic clear_board();
    for (int i = 0; i < 64; i++) begin
      mine_b[i]   = 1'b0;
      preset_b[i] = 1'b0;
    end
  endtask

  // Adjacency model: count mines among the 8 in-range neighbours
  task automatic build_adj();
    for (int y = 0; y < 8; y++) begin
      for (int x = 0; x < 8; x++) begin
        int n;
        n = 0;
        for (int ddy = -1; ddy <= 1; ddy++) begin
          for (int ddx = -1; ddx <= 1; ddx++) begin
            if ((ddx != 0 || ddy != 0) && (x + ddx >= 0) && (x + ddx < 8) &&
                (y + ddy >= 0) && (y + ddy < 8) && mine_b[(y + ddy) * 8 + x + ddx])
              n++;
          end
        end
        adj_b[y * 8 + x] = 4'(n);
      end
    end
    clear_wr = 1'b1;
    @(negedge clk);
    clear_wr = 1'b0;
  endtask

  function automatic int revealed_total();
    int n;
    n = 0;
    for (int i = 0; i < 64; i++) if (wr_b[i] || preset_b[i]) n++;
    return n;
  endfunction

  task automatic run(input int sx, input int sy, output int cycles);
    startX = 3'(sx);
    startY = 3'(sy);
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    cycles = 1;
    while (!qDone && cycles < 3000) begin
      @(negedge clk);
      cycles++;
    end
    check("done_within_budget", int'(qDone), 1);
  endtask

  task automatic do_ack(input string tag);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    check(tag, int'(qInit), 1);
  endtask

  initial begin
    int cyc;
    reset = 1'b1; start = 1'b0; ack = 1'b0; startX = '0; startY = '0;
    clear_wr = 1'b0;
    clear_board();
    build_adj();
    repeat (2) @(negedge clk);

    check("reset_qInit", int'(qInit), 1);
    check("reset_other_states", int'({qFirst, qPop, qScan, qDone}), 0);
    check("reset_count", int'(revealedCount), 0);
    check("reset_hit", int'(hitMine), 0);
    check("reset_wen", int'(revealWriteEn), 0);
    reset = 1'b0;
    @(negedge clk);

    // Click directly on a mine
    clear_board();
    mine_b[3 * 8 + 3] = 1'b1;
    build_adj();
    startX = 3'd3; startY = 3'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("mine_first_state", int'(qFirst), 1);
    check("mine_first_wen", int'(revealWriteEn), 1);
    check("mine_first_wxy", int'({writeY, writeX}), 8'(3 * 8 + 3));
    @(negedge clk);
    check("mine_done_2cyc", int'(qDone), 1);
    check("mine_hit", int'(hitMine), 1);
    check("mine_count", int'(revealedCount), 1);
    check("mine_done_wen", int'(revealWriteEn), 0);
    start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    check("done_ignores_start", int'(qDone), 1);
    check("done_holds_count", int'(revealedCount), 1);
    check("done_holds_hit", int'(hitMine), 1);
    do_ack("mine_ack_init");

    // Numbered cell: adjacency 2, no flood
    clear_board();
    mine_b[3 * 8 + 2] = 1'b1;
    mine_b[3 * 8 + 4] = 1'b1;
    build_adj();
    run(3, 3, cyc);
    check("adj2_count", int'(revealedCount), 1);
    check("adj2_hit", int'(hitMine), 0);
    check("adj2_writes", wr_count, 1);
    check("adj2_cell", int'(wr_b[3 * 8 + 3]), 1);
    do_ack("adj2_ack_init");

    // Empty board from a corner floods everything
    clear_board();
    build_adj();
    run(0, 0, cyc);
    check("empty_count", int'(revealedCount), 64);
    check("empty_hit", int'(hitMine), 0);
    check("empty_writes", wr_count, 64);
    check("empty_dup_writes", dup_writes, 0);
    check("empty_revealed", revealed_total(), 64);
    do_ack("empty_ack_init");

    // Single mine in the far corner stays hidden
    clear_board();
    mine_b[7 * 8 + 7] = 1'b1;
    build_adj();
    run(0, 0, cyc);
    check("corner_count", int'(revealedCount), 63);
    check("corner_hit", int'(hitMine), 0);
    check("corner_mine_hidden", int'(wr_b[7 * 8 + 7]), 0);
    check("corner_mine_writes", mine_writes, 0);
    check("corner_revealed", revealed_total(), 63);
    check("corner_dup_writes", dup_writes, 0);
    do_ack("corner_ack_init");

    // Click on an already revealed cell
    clear_board();
    preset_b[2 * 8 + 2] = 1'b1;
    build_adj();
    run(2, 2, cyc);
    check("prerev_cycles", cyc, 2);
    check("prerev_count", int'(revealedCount), 0);
    check("prerev_writes", wr_count, 0);
    do_ack("prerev_ack_init");

    // Reset in the middle of a flood, then a clean rerun
    clear_board();
    build_adj();
    startX = 3'd0; startY = 3'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!qScan && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("midscan_reached", int'(qScan), 1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midscan_rst_init", int'(qInit), 1);
    check("midscan_rst_count", int'(revealedCount), 0);
    check("midscan_rst_hit", int'(hitMine), 0);
    check("midscan_rst_wen", int'(revealWriteEn), 0);
    reset = 1'b0;
    build_adj();
    run(0, 0, cyc);
    check("rerun_count", int'(revealedCount), 64);
    check("rerun_writes", wr_count, 64);
    check("rerun_dup_writes", dup_writes, 0);
    do_ack("rerun_ack_init");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
